// File: rtl/rv_pipeline_pkg.sv
// rv_pipeline_pkg: shared widths, NOP encoding and fetch-state enum for the RV32 pipeline
package rv_pipeline_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [2:0] {REQ, WAIT, HOLD, DROP, HALT} fetchState_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; squash beats load, stall holds, otherwise a bubble
module if_id_reg
  import rv_pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               squash,
  input  logic               load,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [XLEN-1:0]    pcIn,
  input  logic [XLEN-1:0]    pcPlus4In,
  output logic [INSTR_W-1:0] Instr,
  output logic [XLEN-1:0]    PCD,
  output logic [XLEN-1:0]    PCPlus4D,
  output logic               valid_d
);
  // bubbles keep the last PC pair so decode never sees garbage addresses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      Instr <= NOP_INSTR;
      PCD <= '0;
      PCPlus4D <= '0;
      valid_d <= 1'b0;
    end else if (squash || (!load && !stall)) begin
      Instr <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (load) begin
      Instr <= instrIn;
      PCD <= pcIn;
      PCPlus4D <= pcPlus4In;
      valid_d <= 1'b1;
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch PC, single-outstanding imem handshake and IF/ID register (option IF_MISALIGN_CHECK_EN)
module instruction_fetch
  import rv_pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] Instr,
  output logic [XLEN-1:0]    PCD,
  output logic [XLEN-1:0]    PCPlus4D,
  output logic               valid_d,
  output logic               misalign
);
  fetchState_t state, stateNext;
  logic [XLEN-1:0] pcF, pcNext, pcPlus4, targetPc;
  logic [INSTR_W-1:0] holdBuf, loadInstr;
  logic load, bufWe, reqC, badTarget;
  assign pcPlus4 = pcF + 32'd4;
`ifdef IF_MISALIGN_CHECK_EN
  assign targetPc = redirect_pc;
  assign badTarget = |redirect_pc[1:0];
  // misaligned target latches an error that only reset clears
  always_ff @(posedge clk or posedge rst)
    if (rst) misalign <= 1'b0;
    else if (redirect && badTarget) misalign <= 1'b1;
`else
  assign targetPc = redirect_pc & ~32'h3;
  assign badTarget = 1'b0;
  assign misalign = 1'b0;
`endif
  assign imem_req = reqC & ~rst;
  // next state, next PC, request and IF/ID load; redirect overrides everything below reset
  always_comb begin
    stateNext = state;
    pcNext = pcF;
    reqC = 1'b0;
    imem_addr = pcF;
    load = 1'b0;
    loadInstr = imem_rdata;
    bufWe = 1'b0;
    case (state)
      REQ: begin
        reqC = 1'b1;
        stateNext = WAIT;
      end
      WAIT: if (imem_rvalid) begin
        if (stall || flush) begin
          bufWe = 1'b1;
          stateNext = HOLD;
        end else begin
          load = 1'b1;
          pcNext = pcPlus4;
          reqC = 1'b1;
          imem_addr = pcPlus4;
        end
      end
      HOLD: if (!stall && !flush) begin
        load = 1'b1;
        loadInstr = holdBuf;
        pcNext = pcPlus4;
        stateNext = REQ;
      end
      DROP: if (imem_rvalid) stateNext = REQ;
      default: ;
    endcase
    if (redirect && state != HALT) begin
      reqC = 1'b0;
      load = 1'b0;
      bufWe = 1'b0;
      pcNext = badTarget ? pcF : targetPc;
      stateNext = badTarget ? HALT : (((state == WAIT) && !imem_rvalid) || (state == DROP)) ? DROP : REQ;
    end
  end
  // fetch state and PC registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= REQ;
      pcF <= RESET_PC;
    end else begin
      state <= stateNext;
      pcF <= pcNext;
    end
  // one-entry buffer for a response that lands while decode is stalled or flushed
  always_ff @(posedge clk or posedge rst)
    if (rst) holdBuf <= NOP_INSTR;
    else if (bufWe) holdBuf <= imem_rdata;
  if_id_reg ifId (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .squash(redirect | flush),
    .load(load),
    .instrIn(loadInstr),
    .pcIn(pcF),
    .pcPlus4In(pcPlus4),
    .Instr(Instr),
    .PCD(PCD),
    .PCPlus4D(PCPlus4D),
    .valid_d(valid_d)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven directed checks of the fetch stage plus reset/misalign sequences
module tb_instruction_fetch;
  logic clk, rst, stall, flush, redirect, imem_rvalid, imem_req, valid_d, misalign;
  logic [31:0] redirect_pc, imem_rdata, imem_addr, Instr, PCD, PCPlus4D;
  int total = 0;
  int bad = 0;
  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  typedef struct {
    logic st, fl, rd;
    logic [31:0] rpc;
    logic rv;
    logic [31:0] rdata;
    logic req;
    logic [31:0] addr;
    logic vd;
    logic [31:0] instr, pcd, p4;
  } vec_t;
  vec_t v[29];

  instruction_fetch #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .Instr(Instr), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .valid_d(valid_d), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                       input logic rv, input logic [31:0] rdata);
    stall = st;
    flush = fl;
    redirect = rd;
    redirect_pc = rpc;
    imem_rvalid = rv;
    imem_rdata = rdata;
  endtask

  initial begin
    //        st fl rd rpc           rv rdata          req addr          vd instr          pcd           p4
    v[0]  = '{N, N, N, 32'h0,        N, 32'h0,         Y, 32'h100,       N, 32'h13,        32'h0,        32'h0};
    v[1]  = '{N, N, N, 32'h0,        Y, 32'hAAAA0100,  Y, 32'h104,       N, 32'h13,        32'h0,        32'h0};
    v[2]  = '{N, N, N, 32'h0,        Y, 32'hAAAA0104,  Y, 32'h108,       Y, 32'hAAAA0100,  32'h100,      32'h104};
    v[3]  = '{Y, N, N, 32'h0,        Y, 32'hAAAA0108,  N, 32'h0,         Y, 32'hAAAA0104,  32'h104,      32'h108};
    v[4]  = '{Y, N, N, 32'h0,        N, 32'h0,         N, 32'h0,         Y, 32'hAAAA0104,  32'h104,      32'h108};
    v[5]  = '{Y, N, N, 32'h0,        N, 32'h0,         N, 32'h0,         Y, 32'hAAAA0104,  32'h104,      32'h108};
    v[6]  = '{N, N, N, 32'h0,        N, 32'h0,         N, 32'h0,         Y, 32'hAAAA0104,  32'h104,      32'h108};
    v[7]  = '{N, N, N, 32'h0,        N, 32'h0,         Y, 32'h10C,       Y, 32'hAAAA0108,  32'h108,      32'h10C};
    v[8]  = '{N, N, N, 32'h0,        Y, 32'hAAAA010C,  Y, 32'h110,       N, 32'h13,        32'h108,      32'h10C};
    v[9]  = '{N, Y, N, 32'h0,        Y, 32'hAAAA0110,  N, 32'h0,         Y, 32'hAAAA010C,  32'h10C,      32'h110};
    v[10] = '{N, N, N, 32'h0,        N, 32'h0,         N, 32'h0,         N, 32'h13,        32'h10C,      32'h110};
    v[11] = '{N, N, N, 32'h0,        N, 32'h0,         Y, 32'h114,       Y, 32'hAAAA0110,  32'h110,      32'h114};
    v[12] = '{N, Y, N, 32'h0,        N, 32'h0,         N, 32'h0,         N, 32'h13,        32'h110,      32'h114};
    v[13] = '{N, N, N, 32'h0,        Y, 32'hAAAA0114,  Y, 32'h118,       N, 32'h13,        32'h110,      32'h114};
    v[14] = '{N, N, Y, 32'h200,      N, 32'h0,         N, 32'h0,         Y, 32'hAAAA0114,  32'h114,      32'h118};
    v[15] = '{N, N, N, 32'h0,        N, 32'h0,         N, 32'h0,         N, 32'h13,        32'h114,      32'h118};
    v[16] = '{N, N, N, 32'h0,        Y, 32'hDEADBEEF,  N, 32'h0,         N, 32'h13,        32'h114,      32'h118};
    v[17] = '{N, N, N, 32'h0,        N, 32'h0,         Y, 32'h200,       N, 32'h13,        32'h114,      32'h118};
    v[18] = '{N, N, N, 32'h0,        Y, 32'hAAAA0200,  Y, 32'h204,       N, 32'h13,        32'h114,      32'h118};
    v[19] = '{N, N, Y, 32'h300,      Y, 32'hAAAA0204,  N, 32'h0,         Y, 32'hAAAA0200,  32'h200,      32'h204};
    v[20] = '{N, N, N, 32'h0,        N, 32'h0,         Y, 32'h300,       N, 32'h13,        32'h200,      32'h204};
    v[21] = '{N, N, N, 32'h0,        Y, 32'hAAAA0300,  Y, 32'h304,       N, 32'h13,        32'h200,      32'h204};
    v[22] = '{N, N, N, 32'h0,        N, 32'h0,         N, 32'h0,         Y, 32'hAAAA0300,  32'h300,      32'h304};
    v[23] = '{N, N, N, 32'h0,        Y, 32'hAAAA0304,  Y, 32'h308,       N, 32'h13,        32'h300,      32'h304};
    v[24] = '{N, N, Y, 32'hFFFFFFFC, N, 32'h0,         N, 32'h0,         Y, 32'hAAAA0304,  32'h304,      32'h308};
    v[25] = '{N, N, N, 32'h0,        Y, 32'hDEADBEEF,  N, 32'h0,         N, 32'h13,        32'h304,      32'h308};
    v[26] = '{N, N, N, 32'h0,        N, 32'h0,         Y, 32'hFFFFFFFC,  N, 32'h13,        32'h304,      32'h308};
    v[27] = '{N, N, N, 32'h0,        Y, 32'hAAAAFFFC,  Y, 32'h0,         N, 32'h13,        32'h304,      32'h308};
    v[28] = '{N, N, N, 32'h0,        N, 32'h0,         N, 32'h0,         Y, 32'hAAAAFFFC,  32'hFFFFFFFC, 32'h0};

    rst = 1'b0;
    drive(N, N, N, 32'h0, Y, 32'hBADBAD00);
    #1 rst = 1'b1;
    #2;
    chk("reset imem_req", 32'(imem_req), 32'h0);
    chk("reset Instr", Instr, 32'h13);
    chk("reset PCD", PCD, 32'h0);
    chk("reset PCPlus4D", PCPlus4D, 32'h0);
    chk("reset valid_d", 32'(valid_d), 32'h0);
    chk("reset misalign", 32'(misalign), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      drive(v[i].st, v[i].fl, v[i].rd, v[i].rpc, v[i].rv, v[i].rdata);
      #1;
      chk($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(v[i].req));
      if (v[i].req) chk($sformatf("row%0d imem_addr", i), imem_addr, v[i].addr);
      chk($sformatf("row%0d valid_d", i), 32'(valid_d), 32'(v[i].vd));
      chk($sformatf("row%0d Instr", i), Instr, v[i].instr);
      chk($sformatf("row%0d PCD", i), PCD, v[i].pcd);
      chk($sformatf("row%0d PCPlus4D", i), PCPlus4D, v[i].p4);
      @(negedge clk);
    end

    // misaligned redirect while a fetch for 0x0 is outstanding
    drive(N, N, Y, 32'h202, N, 32'h0);
    #1 chk("mis redirect imem_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    drive(N, N, N, 32'h0, Y, 32'hDEADBEEF);
    #1;
`ifdef IF_MISALIGN_CHECK_EN
    chk("mis flag set", 32'(misalign), 32'h1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(N, N, N, 32'h0, k[0], 32'h12345678);
      #1;
      chk($sformatf("halt%0d imem_req", k), 32'(imem_req), 32'h0);
      chk($sformatf("halt%0d valid_d", k), 32'(valid_d), 32'h0);
      chk($sformatf("halt%0d misalign", k), 32'(misalign), 32'h1);
    end
`else
    chk("mis flag tied", 32'(misalign), 32'h0);
    chk("mis drop imem_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    drive(N, N, N, 32'h0, N, 32'h0);
    #1;
    chk("mis masked imem_req", 32'(imem_req), 32'h1);
    chk("mis masked imem_addr", imem_addr, 32'h200);
    chk("mis masked valid_d", 32'(valid_d), 32'h0);
`endif
    @(negedge clk);

    // reset mid-transaction with responses arriving during and right after reset
    rst = 1'b1;
    drive(N, N, N, 32'h0, N, 32'h0);
    #1;
    chk("rst2 imem_req", 32'(imem_req), 32'h0);
    chk("rst2 misalign", 32'(misalign), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2 first req", 32'(imem_req), 32'h1);
    chk("rst2 first addr", imem_addr, 32'h100);
    @(negedge clk);
    rst = 1'b1;
    drive(N, N, N, 32'h0, Y, 32'hBADBAD01);
    #1 chk("rst3 imem_req", 32'(imem_req), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst3 first req", 32'(imem_req), 32'h1);
    chk("rst3 first addr", imem_addr, 32'h100);
    @(negedge clk);
    drive(N, N, N, 32'h0, N, 32'h0);
    #1;
    chk("rst3 early rvalid dropped", 32'(valid_d), 32'h0);
    chk("rst3 wait no req", 32'(imem_req), 32'h0);
    @(negedge clk);
    drive(N, N, N, 32'h0, Y, 32'hAAAA0100);
    #1;
    chk("rst3 next req", 32'(imem_req), 32'h1);
    chk("rst3 next addr", imem_addr, 32'h104);
    @(negedge clk);
    drive(N, N, N, 32'h0, N, 32'h0);
    #1;
    chk("rst3 valid_d", 32'(valid_d), 32'h1);
    chk("rst3 Instr", Instr, 32'hAAAA0100);
    chk("rst3 PCD", PCD, 32'h100);
    chk("rst3 PCPlus4D", PCPlus4D, 32'h104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
